// File: rtl/mem_arbiter_if.sv
// Signal bundle between the icache, the dcache, the arbiter and the shared RAM.
// The arbiter takes the slave modport; the caches and RAM together form the master side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache normally wins, but the icache is guaranteed a grant
// after STARVE_LIMIT consecutive dcache grants taken while it was waiting.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_arbiter_if.slave      bus,
    output logic [1:0]        grant_state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IGRANT  = 2'd1,
        DGRANT  = 2'd2,
        ILLEGAL = 2'd3
    } grant_state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);

    grant_state_t state;
    grant_state_t next_state;
    logic [2:0]   starve_cnt;
    logic [2:0]   next_starve_cnt;
    logic         d_req;
    logic         ram_done;

    assign d_req    = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_starve_cnt;
        end
    end

    // Every grant returns through IDLE, so all arbitration decisions happen here only.
    always_comb begin
        next_state      = state;
        next_starve_cnt = starve_cnt;
        case (state)
            IDLE: begin
                if (d_req && !(bus.iREN && starve_cnt == LIMIT)) begin
                    next_state = DGRANT;
                    if (!bus.iREN)
                        next_starve_cnt = '0;
                    else if (starve_cnt < LIMIT)
                        next_starve_cnt = starve_cnt + 3'd1;
                end else if (bus.iREN) begin
                    next_state      = IGRANT;
                    next_starve_cnt = '0;
                end
            end
            IGRANT: begin
                if (!bus.iREN || ram_done)
                    next_state = IDLE;
            end
            DGRANT: begin
                if (!d_req || ram_done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // RAM controls follow the grant combinationally, so reset drops them immediately.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~ram_done;
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~ram_done;
            end
            default: ;
        endcase
    end

    assign bus.iload       = bus.ramload;
    assign bus.dload       = bus.ramload;
    assign grant_state_out = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] grant_state_out;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .bus            (bus.slave),
        .grant_state_out(grant_state_out)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 = nobody, 1 = icache, 2 = dcache; m_cnt = dcache wins while icache waited.
    int m_state = 0;
    int m_cnt   = 0;
    int obs_log[$];
    logic [1:0] prev_obs = 2'd0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iren, input logic [31:0] ia,
                                 input logic dren, input logic dwen,
                                 input logic [31:0] da, input logic [31:0] ds,
                                 input logic [31:0] rl, input logic [1:0] rs);
        bus.iREN     = iren;
        bus.iaddr    = ia;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramload  = rl;
        bus.ramstate = rs;
    endtask

    task automatic checkModel(input string tag);
        logic        done;
        logic        e_ren, e_wen, e_iwait, e_dwait;
        logic [31:0] e_addr, e_store;
        done    = (bus.ramstate == 2'd2);
        e_ren   = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
        e_iwait = 1'b1; e_dwait = 1'b1;
        if (m_state == 1) begin
            e_ren = 1'b1; e_addr = bus.iaddr; e_iwait = !done;
        end else if (m_state == 2) begin
            e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
            e_addr = bus.daddr; e_store = bus.dstore; e_dwait = !done;
        end
        checkOutput({tag, ".state"},    32'(grant_state_out), 32'(m_state));
        checkOutput({tag, ".ramREN"},   32'(bus.ramREN),      32'(e_ren));
        checkOutput({tag, ".ramWEN"},   32'(bus.ramWEN),      32'(e_wen));
        checkOutput({tag, ".ramaddr"},  bus.ramaddr,          e_addr);
        checkOutput({tag, ".ramstore"}, bus.ramstore,         e_store);
        checkOutput({tag, ".iwait"},    32'(bus.iwait),       32'(e_iwait));
        checkOutput({tag, ".dwait"},    32'(bus.dwait),       32'(e_dwait));
        checkOutput({tag, ".iload"},    bus.iload,            bus.ramload);
        checkOutput({tag, ".dload"},    bus.dload,            bus.ramload);
    endtask

    task automatic modelStep();
        bit dreq, done;
        dreq = bus.dREN || bus.dWEN;
        done = (bus.ramstate == 2'd2);
        if (!nRST) begin
            m_state = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            if (dreq && bus.iREN) begin
                if (m_cnt == LIMIT) begin m_state = 1; m_cnt = 0; end
                else begin m_state = 2; m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1; end
            end else if (dreq) begin
                m_state = 2; m_cnt = 0;
            end else if (bus.iREN) begin
                m_state = 1; m_cnt = 0;
            end
        end else if (m_state == 1) begin
            if (!bus.iREN || done) m_state = 0;
        end else begin
            if (!dreq || done) m_state = 0;
        end
    endtask

    task automatic sampleCycle(input string tag);
        @(negedge CLK);
        checkModel(tag);
        if (grant_state_out != 2'd0 && prev_obs == 2'd0) obs_log.push_back(int'(grant_state_out));
        prev_obs = grant_state_out;
    endtask

    task automatic advance();
        modelStep();
        @(posedge CLK);
        #1;
    endtask

    task automatic runCycle(input string tag);
        sampleCycle(tag);
        advance();
    endtask

    int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        nRST = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        #2;
        checkModel("reset");
        @(posedge CLK); #1;
        nRST = 1'b1;

        $display("[TB] starvation sequence");
        obs_log.delete();
        prev_obs = 2'd0;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 32'hAA, 2'd2);
        for (int i = 0; i < 40 && obs_log.size() < 10; i++) runCycle("starve");
        checkOutput("starve.count", 32'(obs_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < obs_log.size(); i++)
            checkOutput($sformatf("starve.grant%0d", i), 32'(obs_log[i]), 32'(exp_seq[i]));

        $display("[TB] icache read with busy RAM");
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 2'd1);
        runCycle("iread.req");
        for (int i = 0; i < 2; i++) begin
            sampleCycle("iread.busy");
            checkOutput("iread.busy.ramREN", 32'(bus.ramREN), 32'd1);
            checkOutput("iread.busy.ramaddr", bus.ramaddr, 32'h40);
            advance();
        end
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 2'd2);
        sampleCycle("iread.access");
        checkOutput("iread.access.iwait", 32'(bus.iwait), 32'd0);
        checkOutput("iread.access.iload", bus.iload, 32'hDEADBEEF);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        sampleCycle("iread.done");
        checkOutput("iread.done.state", 32'(grant_state_out), 32'd0);
        advance();

        $display("[TB] dcache write wins over read");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0, 2'd1);
        runCycle("dwrite.req");
        sampleCycle("dwrite.busy");
        checkOutput("dwrite.ramWEN", 32'(bus.ramWEN), 32'd1);
        checkOutput("dwrite.ramREN", 32'(bus.ramREN), 32'd0);
        checkOutput("dwrite.ramstore", bus.ramstore, 32'h1234);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0, 2'd2);
        sampleCycle("dwrite.access");
        checkOutput("dwrite.access.dwait", 32'(bus.dwait), 32'd0);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        runCycle("dwrite.done");

        $display("[TB] dcache request withdrawn");
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h90, 32'h0, 32'h0, 2'd1);
        runCycle("drop.req");
        runCycle("drop.busy");
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h90, 32'h0, 32'h0, 2'd1);
        sampleCycle("drop.release");
        checkOutput("drop.release.dwait", 32'(bus.dwait), 32'd1);
        advance();
        sampleCycle("drop.idle");
        checkOutput("drop.idle.state", 32'(grant_state_out), 32'd0);
        advance();
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2);
        runCycle("drop.igrant");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        runCycle("drop.done");

        $display("[TB] RAM error holds grant");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hA0, 32'h0, 32'h5555, 2'd3);
        runCycle("err.req");
        for (int i = 0; i < 5; i++) begin
            sampleCycle("err.hold");
            checkOutput("err.hold.dwait", 32'(bus.dwait), 32'd1);
            checkOutput("err.hold.state", 32'(grant_state_out), 32'd2);
            advance();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hA0, 32'h0, 32'h5555, 2'd2);
        sampleCycle("err.access");
        checkOutput("err.access.dwait", 32'(bus.dwait), 32'd0);
        checkOutput("err.access.dload", bus.dload, 32'h5555);
        advance();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        runCycle("err.done");

        $display("[TB] reset during icache grant");
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1);
        runCycle("rst.req");
        sampleCycle("rst.busy");
        checkOutput("rst.busy.ramREN", 32'(bus.ramREN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        checkOutput("rst.async.ramREN", 32'(bus.ramREN), 32'd0);
        checkOutput("rst.async.state", 32'(grant_state_out), 32'd0);
        checkOutput("rst.async.iwait", 32'(bus.iwait), 32'd1);
        m_state = 0;
        m_cnt   = 0;
        @(posedge CLK); #1;
        runCycle("rst.held");
        nRST = 1'b1;
        runCycle("rst.release");
        sampleCycle("rst.regrant");
        checkOutput("rst.regrant.state", 32'(grant_state_out), 32'd1);
        advance();
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2);
        runCycle("rst.access");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] rs;
            r  = int'($urandom_range(0, 7));
            rs = (r < 4) ? 2'd2 : 2'(r - 4);
            applyStimulus($urandom_range(0, 3) != 0, $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                          $urandom, $urandom, $urandom, rs);
            runCycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, meaning the maximum number of consecutive dcache grants allowed while an icache request is pending; legal range 1..7.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  1  icache fill read request.
REQ-005 iaddr  input  32  icache request word address.
REQ-006 iwait  output  1  low for exactly the cycle icache data is valid.
REQ-007 iload  output  32  icache read data.
REQ-008 dREN  input  1  dcache read request.
REQ-009 dWEN  input  1  dcache write request.
REQ-010 daddr  input  32  dcache request address.
REQ-011 dstore  input  32  dcache write data.
REQ-012 dwait  output  1  low for exactly the cycle the dcache access completes.
REQ-013 dload  output  32  dcache read data.
REQ-014 ramREN  output  1  RAM read enable.
REQ-015 ramWEN  output  1  RAM write enable.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data.
REQ-019 ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 grant_state_out  output  2  current FSM state, for debug.

Function
REQ-021 The FSM SHALL have three states: IDLE=0, IGRANT=1, DGRANT=2; encoding 3 is illegal and SHALL return to IDLE on the next edge.
REQ-022 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0, and iwait and dwait SHALL both be 1.
REQ-023 From IDLE with only dREN|dWEN asserted, the next state SHALL be DGRANT.
REQ-024 From IDLE with only iREN asserted, the next state SHALL be IGRANT.
REQ-025 From IDLE with both requesters asserted, the next state SHALL be DGRANT unless the starve counter equals STARVE_LIMIT, in which case it SHALL be IGRANT.
REQ-026 In IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr and ramstore=0, all combinational from the current inputs.
REQ-027 In DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are asserted), ramaddr=daddr and ramstore=dstore.
REQ-028 iload SHALL equal ramload at all times, and dload SHALL equal ramload at all times; they are meaningful only when the matching wait signal is low.
REQ-029 iwait SHALL be low only when state==IGRANT and ramstate==ACCESS.
REQ-030 dwait SHALL be low only when state==DGRANT and ramstate==ACCESS.
REQ-031 A granted state SHALL hold through FREE, BUSY and ERROR, and SHALL transition to IDLE on the edge following an ACCESS cycle. This gives one mandatory bubble cycle between grants.
REQ-032 If the granted requester deasserts its request before ACCESS, the FSM SHALL go to IDLE on the next edge and SHALL NOT emit a wait-low pulse.
REQ-033 Starve counter width: 3 bits, unsigned.
REQ-034 On each IDLE->DGRANT transition taken while iREN=1, the starve counter SHALL increment, saturating at STARVE_LIMIT.
REQ-035 On each IDLE->IGRANT transition, the starve counter SHALL clear to 0.
REQ-036 On an IDLE->DGRANT transition with iREN=0, the starve counter SHALL clear to 0.
REQ-037 Minimum latency: request asserted in IDLE at cycle N -> grant at N+1 -> earliest wait-low at N+1 if RAM returns ACCESS immediately.
REQ-038 ramstate ERROR SHALL be treated as not-complete: the grant is held and no wait-low pulse is issued.

Reset
REQ-039 While nRST=0: state=IDLE, starve counter=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, grant_state_out=0.
REQ-040 Reset asserted mid-grant SHALL abort the access immediately, with RAM enables low asynchronously.
REQ-041 After reset deasserts, the first grant SHALL follow REQ-023 to REQ-025.

Verification
REQ-042 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 for 3 cycles; iwait low 1 cycle with iload=0xDEADBEEF; then IDLE.
REQ-043 dWEN=1 and dREN=1 together, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234; dwait low on ACCESS.
REQ-044 iREN and dREN held continuously, RAM always ACCESS, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I, with an IDLE cycle between each grant.
REQ-045 dREN dropped during BUSY in DGRANT -> IDLE next cycle, dwait never low, counter unchanged.
REQ-046 nRST pulsed low during IGRANT with ramstate BUSY -> ramREN=0 immediately, state=IDLE, counter=0; a pending iREN is regranted one cycle after reset release.
REQ-047 ramstate ERROR held 5 cycles in DGRANT -> grant held, dwait=1 throughout; ACCESS on the 6th cycle -> dwait low for 1 cycle.
